// File: rtl/bc0_align_auto_pkg.sv
// bc0_align_pkg: shared mode encoding and default sizing for the BC0 alignment monitor
package bc0_align_pkg;
    typedef enum logic [1:0] {
        MODE_USER   = 2'd0,
        MODE_AUTO   = 2'd1,
        MODE_FREEZE = 2'd2
    } mode_e;
    localparam int FC_DEF       = 49;
    localparam int CW_DEF       = 8;
    localparam int DW_DEF       = 9;
    localparam int WIN_LO_DEF   = 10;
    localparam int WIN_HI_DEF   = 58;
    localparam int STABLE_N_DEF = 4;
    localparam logic [CW_DEF-1:0] CNT_NONE = '1;
endpackage

// File: rtl/bc0_align_auto_if.sv
// bc0_align_auto_if: link-side inputs and per-fiber alignment results of the BC0 monitor
interface bc0_align_auto_if #(
    parameter int FC = 49,
    parameter int CW = 8,
    parameter int DW = 9
) ();
    logic                  ttc_bc0;
    logic [DW-1:0]         ttc_bc0_delay;
    logic [FC-1:0]         bc0;
    logic [1:0]            mode;
    logic [FC-1:0][CW-1:0] user_af_delays;
    logic [FC-1:0][CW-1:0] time_counts;
    logic [FC-1:0][CW-1:0] af_delays;
    logic [FC-1:0]         alignment_error;
    logic [FC-1:0]         locked;
    logic                  all_locked;
    logic [15:0]           orbit_cnt;
    modport master (
        output ttc_bc0, ttc_bc0_delay, bc0, mode, user_af_delays,
        input  time_counts, af_delays, alignment_error, locked, all_locked, orbit_cnt
    );
    modport slave (
        input  ttc_bc0, ttc_bc0_delay, bc0, mode, user_af_delays,
        output time_counts, af_delays, alignment_error, locked, all_locked, orbit_cnt
    );
endinterface

// File: rtl/bc0_align_auto_max_tree.sv
// bc0_max_tree: registered maximum over the values whose mask bit is set
module bc0_max_tree #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0][W-1:0] vals,
    input  logic [N-1:0]      mask,
    output logic [W-1:0]      vmax,
    output logic              any
);
    logic [W-1:0] mx;

    // masked maximum; zero is a safe floor since counts are unsigned
    always_comb begin
        mx = '0;
        for (int i = 0; i < N; i++)
            if (mask[i] && vals[i] > mx) mx = vals[i];
    end

    // one register stage on the result and the any-valid flag
    always_ff @(posedge clk) begin
        if (rst) begin
            vmax <= '0;
            any  <= 1'b0;
        end else begin
            vmax <= mx;
            any  <= |mask;
        end
    end
endmodule

// File: rtl/bc0_align_auto.sv
// bc0_align_auto: per-fiber BC0 phase monitor with lock tracking and automatic delay derivation
module bc0_align_auto
    import bc0_align_pkg::*;
#(
    parameter int FC       = FC_DEF,
    parameter int CW       = CW_DEF,
    parameter int DW       = DW_DEF,
    parameter int WIN_LO   = WIN_LO_DEF,
    parameter int WIN_HI   = WIN_HI_DEF,
    parameter int STABLE_N = STABLE_N_DEF
) (
    input logic clk_160,
    input logic rst,
    bc0_align_auto_if.slave bus
);
    localparam int SW = $clog2(STABLE_N + 1);

    logic                  r1, r2, r3, e, s, act, s1, v2, any, al;
    logic [DW-1:0]         dly;
    logic [FC-1:0]         bp, fe, seen, err, lk, cerr, lk_n;
    logic [FC-1:0][CW-1:0] cnt, tc, cap, af;
    logic [FC-1:0][SW-1:0] stab, stab_n;
    logic [CW-1:0]         m;
    logic [15:0]           orb;

    assign e  = r2 & ~r3;
    assign s  = e ? (bus.ttc_bc0_delay == DW'(1)) : (act && dly == DW'(1));
    assign fe = bus.bc0 & ~bp;

    // TTC synchroniser and strobe delay; loading D-1 lets D=1 fire on the edge cycle itself
    always_ff @(posedge clk_160) begin
        if (rst) begin
            r1  <= 1'b0;
            r2  <= 1'b0;
            r3  <= 1'b0;
            dly <= '1;
            act <= 1'b0;
        end else begin
            r1 <= bus.ttc_bc0;
            r2 <= r1;
            r3 <= r2;
            if (e) begin
                dly <= bus.ttc_bc0_delay - DW'(1);
                act <= bus.ttc_bc0_delay > DW'(1);
            end else if (act) begin
                dly <= dly - DW'(1);
                act <= dly > DW'(1);
            end
        end
    end

    // per-fiber tick counters since the last BC0 edge, saturating rather than wrapping
    always_ff @(posedge clk_160) begin
        if (rst) begin
            bp   <= '0;
            cnt  <= '1;
            seen <= '0;
        end else begin
            bp <= bus.bc0;
            for (int i = 0; i < FC; i++) begin
                cnt[i]  <= fe[i] ? '0 : (&cnt[i] ? cnt[i] : cnt[i] + CW'(1));
                seen[i] <= fe[i] | (seen[i] & ~s);
            end
        end
    end

    // next capture, window check and stability count for every fiber
    always_comb begin
        cap    = '1;
        cerr   = '0;
        stab_n = '0;
        lk_n   = '0;
        for (int i = 0; i < FC; i++) begin
            cap[i]    = seen[i] ? cnt[i] : '1;
            cerr[i]   = (&cap[i]) || cap[i] < CW'(WIN_LO) || cap[i] > CW'(WIN_HI);
            stab_n[i] = (cap[i] == tc[i] && !cerr[i]) ?
                        (stab[i] == SW'(STABLE_N) ? stab[i] : stab[i] + SW'(1)) : '0;
            lk_n[i]   = stab_n[i] == SW'(STABLE_N);
        end
    end

    // register the measurement on each strobe; s1/v2 track the AUTO pipeline stages
    always_ff @(posedge clk_160) begin
        if (rst) begin
            tc   <= '1;
            err  <= '0;
            stab <= '0;
            lk   <= '0;
            al   <= 1'b0;
            orb  <= '0;
            s1   <= 1'b0;
            v2   <= 1'b0;
        end else begin
            s1 <= s;
            v2 <= s1;
            if (s) begin
                tc   <= cap;
                err  <= cerr;
                stab <= stab_n;
                lk   <= lk_n;
                al   <= &lk_n;
                orb  <= orb + 16'd1;
            end
        end
    end

    bc0_max_tree #(.N(FC), .W(CW)) u_max (
        .clk  (clk_160),
        .rst  (rst),
        .vals (tc),
        .mask (lk),
        .vmax (m),
        .any  (any)
    );

    // applied delays: copy user values, or pad locked fibers up to the latest one in AUTO
    always_ff @(posedge clk_160) begin
        if (rst)
            af <= '0;
        else if (bus.mode == MODE_USER)
            af <= bus.user_af_delays;
        else if (bus.mode == MODE_AUTO && v2 && any)
            for (int i = 0; i < FC; i++)
                if (lk[i]) af[i] <= m - tc[i];
    end

    assign bus.time_counts     = tc;
    assign bus.af_delays       = af;
    assign bus.alignment_error = err;
    assign bus.locked          = lk;
    assign bus.all_locked      = al;
    assign bus.orbit_cnt       = orb;
endmodule

// File: tb/tb_bc0_align_auto.sv
// tb_bc0_align_auto: orbit-table scoreboard plus hand-built corner sequences for the BC0 monitor
module tb_bc0_align_auto;
    import bc0_align_pkg::*;

    typedef logic [3:0][7:0] v4_t;
    typedef struct {
        v4_t        c;
        logic [1:0] mode;
        v4_t        user;
        v4_t        tc;
        logic [3:0] err;
        logic [3:0] lk;
        v4_t        af;
    } vec_t;
    typedef struct {
        v4_t        tc;
        logic [3:0] err;
        logic [3:0] lk;
        logic [15:0] orb;
        v4_t        af;
    } exp_t;

    logic clk_160 = 1'b0;
    logic rst = 1'b1;
    always #5 clk_160 = ~clk_160;

    bc0_align_auto_if #(.FC(4), .CW(8), .DW(9)) bus ();
    bc0_align_auto #(.FC(4), .CW(8), .DW(9)) dut (.clk_160(clk_160), .rst(rst), .bus(bus));

    vec_t        tbl[16];
    exp_t        q[$];
    int          nvec = 0;
    int          nerr = 0;
    bit          sb_on = 1'b0;
    logic [15:0] last_orb = '0;
    int          af_due = 0;
    v4_t         af_exp;
    v4_t         A, B, C, Z, U, AF1, AF2, NONE4;

    function automatic v4_t v4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        nvec++;
        if (a !== x) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", n, a, x);
        end
    endtask

    // one 100-cycle orbit: TTC at j=29 gives E at 31 and S at 70 with D=40; count c means an edge at 69-c
    task automatic frame(input v4_t c, input int xj, input int rj);
        logic [3:0] b;
        for (int j = 0; j < 100; j++) begin
            bus.ttc_bc0 = (j >= 29 && j < 33);
            for (int i = 0; i < 4; i++)
                b[i] = (c[i] != 8'hFF) && j >= 69 - int'(c[i]) && j < 72 - int'(c[i]);
            if (xj >= 0 && j >= xj && j < xj + 3) b[0] = 1'b1;
            bus.bc0 = b;
            rst = (j == rj);
            @(posedge clk_160);
            #1;
        end
    endtask

    // scoreboard side: a new orbit_cnt means a capture has landed
    always @(negedge clk_160) begin
        exp_t x;
        if (af_due > 0) begin
            af_due--;
            if (af_due == 0) chk("af_delays", bus.af_delays, af_exp);
        end
        if (sb_on && bus.orbit_cnt !== last_orb) begin
            if (q.size() == 0) begin
                chk("unexpected_capture", {16'd0, bus.orbit_cnt}, {16'd0, last_orb});
            end else begin
                x = q.pop_front();
                chk("time_counts", bus.time_counts, x.tc);
                chk("alignment_error", {28'd0, bus.alignment_error}, {28'd0, x.err});
                chk("locked", {28'd0, bus.locked}, {28'd0, x.lk});
                chk("all_locked", {31'd0, bus.all_locked}, {31'd0, &x.lk});
                chk("orbit_cnt", {16'd0, bus.orbit_cnt}, {16'd0, x.orb});
                af_exp = x.af;
                af_due = 2;
            end
        end
        last_orb = bus.orbit_cnt;
    end

    initial begin
        A     = v4(12, 20, 30, 58);
        B     = v4(12, 21, 30, 58);
        C     = v4(14, 22, 32, 50);
        Z     = v4(0, 0, 0, 0);
        U     = v4(5, 6, 7, 8);
        AF1   = v4(46, 38, 28, 0);
        AF2   = v4(46, 37, 28, 0);
        NONE4 = {4{CNT_NONE}};
        for (int k = 0; k < 5; k++)
            tbl[k] = '{A, MODE_AUTO, Z, A, 4'b0000, (k == 4) ? 4'b1111 : 4'b0000, (k == 4) ? AF1 : Z};
        tbl[5] = '{v4(12, 20, 255, 58), MODE_AUTO, Z, v4(12, 20, 255, 58), 4'b0100, 4'b1011, AF1};
        for (int k = 6; k < 10; k++)
            tbl[k] = '{B, MODE_AUTO, Z, B, 4'b0000, 4'b1001, AF1};
        tbl[10] = '{B, MODE_AUTO, Z, B, 4'b0000, 4'b1111, AF2};
        tbl[11] = '{B, MODE_USER, U, B, 4'b0000, 4'b1111, U};
        tbl[12] = '{C, MODE_FREEZE, Z, C, 4'b0000, 4'b0000, U};
        tbl[13] = '{C, MODE_AUTO, Z, C, 4'b0000, 4'b0000, U};
        tbl[14] = '{v4(5, 22, 60, 50), MODE_AUTO, Z, v4(5, 22, 60, 50), 4'b0101, 4'b0000, U};
        tbl[15] = '{v4(10, 22, 59, 50), MODE_AUTO, Z, v4(10, 22, 59, 50), 4'b0100, 4'b0000, U};

        bus.ttc_bc0        = 1'b0;
        bus.ttc_bc0_delay  = 9'd40;
        bus.bc0            = '0;
        bus.mode           = MODE_AUTO;
        bus.user_af_delays = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk_160);
        #1;
        rst = 1'b0;
        chk("reset_time_counts", bus.time_counts, NONE4);
        chk("reset_error", {28'd0, bus.alignment_error}, 32'd0);
        chk("reset_locked", {28'd0, bus.locked}, 32'd0);
        chk("reset_all_locked", {31'd0, bus.all_locked}, 32'd0);
        chk("reset_af_delays", bus.af_delays, 32'd0);
        chk("reset_orbit_cnt", {16'd0, bus.orbit_cnt}, 32'd0);

        sb_on = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.mode           = tbl[k].mode;
            bus.user_af_delays = tbl[k].user;
            q.push_back('{tbl[k].tc, tbl[k].err, tbl[k].lk, 16'(k + 1), tbl[k].af});
            frame(tbl[k].c, -1, -1);
        end
        sb_on = 1'b0;
        chk("scoreboard_drained", q.size(), 32'd0);

        // fiber 0 edge lands on the strobe cycle: old count reported, edge still counts next orbit
        frame(v4(30, 22, 59, 50), 70, -1);
        chk("coincident_old_count", {24'd0, bus.time_counts[0]}, 32'd30);
        frame(v4(255, 22, 59, 50), -1, -1);
        chk("coincident_next_count", {24'd0, bus.time_counts[0]}, 32'd99);
        chk("coincident_next_error", {31'd0, bus.alignment_error[0]}, 32'd1);

        bus.ttc_bc0_delay = 9'd0;
        frame(v4(30, 22, 59, 50), -1, -1);
        chk("delay0_orbit_frozen", {16'd0, bus.orbit_cnt}, 32'd18);
        bus.ttc_bc0_delay = 9'd40;

        frame(v4(40, 255, 255, 255), -1, 50);
        chk("midrst_time_counts", bus.time_counts, NONE4);
        chk("midrst_error", {28'd0, bus.alignment_error}, 32'd0);
        chk("midrst_locked", {28'd0, bus.locked}, 32'd0);
        chk("midrst_all_locked", {31'd0, bus.all_locked}, 32'd0);
        chk("midrst_af_delays", bus.af_delays, 32'd0);
        chk("midrst_orbit_cnt", {16'd0, bus.orbit_cnt}, 32'd0);
        frame(v4(255, 12, 255, 255), -1, -1);
        chk("post_rst_capture", bus.time_counts, v4(255, 12, 255, 255));
        chk("post_rst_orbit", {16'd0, bus.orbit_cnt}, 32'd1);

        repeat (5) frame(v4(20, 30, 40, 50), -1, -1);
        chk("relock_locked", {28'd0, bus.locked}, 32'hF);
        chk("relock_all_locked", {31'd0, bus.all_locked}, 32'd1);
        chk("relock_af_delays", bus.af_delays, v4(30, 20, 10, 0));
        chk("relock_orbit", {16'd0, bus.orbit_cnt}, 32'd6);
        frame(v4(20, 30, 40, 50), -1, 72);
        chk("s2rst_af_delays", bus.af_delays, 32'd0);
        chk("s2rst_locked", {28'd0, bus.locked}, 32'd0);
        chk("s2rst_orbit", {16'd0, bus.orbit_cnt}, 32'd0);
        chk("s2rst_time_counts", bus.time_counts, NONE4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
